// File: rtl/lb_arbiter.sv
// Local-bus arbiter: non-stallable gateway master A has absolute priority over request/ack sequencer B; bus command registered (+1 cycle).
// A read data returns LAT+1 cycles after a_strobe (size the gateway read pipeline to LAT+1); B is held in ISSUE while A strobes.
module lb_arbiter #(
    parameter int LAT   = 3,
    parameter int DFR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      a_addr,
    input  logic             a_strobe,
    input  logic             a_rd,
    input  logic [31:0]      a_wdata,
    output logic [31:0]      a_rdata,
    output logic             a_rd_valid,
    input  logic             b_req,
    input  logic [23:0]      b_addr,
    input  logic             b_rd,
    input  logic [31:0]      b_wdata,
    output logic             b_ack,
    output logic [31:0]      b_rdata,
    output logic             b_busy,
    output logic [23:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    output logic             bus_strobe,
    output logic             bus_rd,
    output logic             bus_write,
    input  logic [31:0]      bus_rdata,
    output logic [DFR_W-1:0] dfr_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

    typedef struct packed {
        logic [23:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic [DFR_W-1:0] DFR_MAX = '1;

    state_t         state;
    cmd_t           b_cmd;
    logic           bus_owner;
    logic [LAT-1:0] tag_vld;
    logic [LAT-1:0] tag_own;
    logic           b_go;
    logic           tag_b_done;

    assign b_go       = (state == ISSUE) && !a_strobe;
    assign tag_b_done = tag_vld[LAT-1] && tag_own[LAT-1];
    assign a_rd_valid = tag_vld[LAT-1] && !tag_own[LAT-1];
    assign a_rdata    = bus_rdata;
    assign b_busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_strobe <= 1'b0;
            bus_write  <= 1'b0;
            bus_rd     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_owner  <= 1'b0;
        end else begin
            bus_strobe <= a_strobe || b_go;
            bus_write  <= (a_strobe && !a_rd) || (b_go && !b_cmd.rd);
            if (a_strobe) begin
                bus_addr  <= a_addr;
                bus_wdata <= a_wdata;
                bus_rd    <= a_rd;
                bus_owner <= 1'b0;
            end else if (b_go) begin
                bus_addr  <= b_cmd.addr;
                bus_wdata <= b_cmd.wdata;
                bus_rd    <= b_cmd.rd;
                bus_owner <= 1'b1;
            end
        end
    end

    // Tag pipe is fed from the registered bus, so its last stage lines up with bus_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= bus_strobe && bus_rd;
            tag_own[0] <= bus_owner;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dfr_count <= '0;
        end else if ((state == ISSUE) && a_strobe && (dfr_count != DFR_MAX)) begin
            dfr_count <= dfr_count + DFR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            b_cmd   <= '0;
            b_ack   <= 1'b0;
            b_rdata <= '0;
        end else begin
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (b_req) begin
                        b_cmd <= '{addr: b_addr, rd: b_rd, wdata: b_wdata};
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!a_strobe) begin
                        if (b_cmd.rd) begin
                            state <= WAIT_RD;
                        end else begin
                            b_ack <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_RD: begin
                    if (tag_b_done) begin
                        b_rdata <= bus_rdata;
                        b_ack   <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_arbiter.sv
// Scoreboard bench for lb_arbiter: tasks push expected bus commands and read results, a negedge monitor collects what the DUT produces.
module tb_lb_arbiter;
    localparam int LAT     = 3;
    localparam int DFR_W   = 8;
    localparam int DFR_MAX = (1 << DFR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [23:0]      a_addr;
    logic             a_strobe;
    logic             a_rd;
    logic [31:0]      a_wdata;
    logic [31:0]      a_rdata;
    logic             a_rd_valid;
    logic             b_req;
    logic [23:0]      b_addr;
    logic             b_rd;
    logic [31:0]      b_wdata;
    logic             b_ack;
    logic [31:0]      b_rdata;
    logic             b_busy;
    logic [23:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic             bus_strobe;
    logic             bus_rd;
    logic             bus_write;
    logic [31:0]      bus_rdata;
    logic [DFR_W-1:0] dfr_count;

    lb_arbiter #(.LAT(LAT), .DFR_W(DFR_W)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_strobe(a_strobe), .a_rd(a_rd), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rd_valid(a_rd_valid),
        .b_req(b_req), .b_addr(b_addr), .b_rd(b_rd), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_busy(b_busy),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
        .bus_rd(bus_rd), .bus_write(bus_write), .bus_rdata(bus_rdata),
        .dfr_count(dfr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int dfr_exp = 0;
    logic [31:0] last_b = 32'h0;

    // entries are {cycle, payload}
    logic [63:0] a_exp[$], a_obs[$], b_exp[$], b_obs[$];
    logic [89:0] bus_exp[$], bus_obs[$];
    int          rq_due[$];
    logic [23:0] rq_addr[$];

    function automatic logic [31:0] slave_data(input logic [23:0] addr);
        return (addr == 24'h000010) ? 32'hDEADBEEF : {8'h5A, addr};
    endfunction

    // Slave: read data valid exactly LAT cycles after its strobe, noise otherwise.
    initial begin
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (bus_strobe && bus_rd) begin
                rq_due.push_back(cyc + LAT);
                rq_addr.push_back(bus_addr);
            end
            if (rq_due.size() > 0 && rq_due[0] == cyc) begin
                bus_rdata = slave_data(rq_addr[0]);
                void'(rq_due.pop_front());
                void'(rq_addr.pop_front());
            end else begin
                bus_rdata = 32'hBAD00000 | 32'(cyc);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (a_rd_valid) a_obs.push_back({32'(cyc), a_rdata});
        if (b_ack) b_obs.push_back({32'(cyc), b_rdata});
        if (bus_strobe) bus_obs.push_back({32'(cyc), bus_rd, bus_write, bus_addr, bus_wdata});
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic a_issue(input logic [23:0] addr, input logic rd, input logic [31:0] wdata);
        a_strobe = 1'b1; a_addr = addr; a_rd = rd; a_wdata = wdata;
        bus_exp.push_back({32'(cyc + 1), rd, !rd, addr, wdata});
        if (rd) a_exp.push_back({32'(cyc + 1 + LAT), slave_data(addr)});
    endtask

    task automatic a_idle();
        a_strobe = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++;
        if ({bus_strobe, bus_rd, bus_write, a_rd_valid, b_ack, b_busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 000000", {bus_strobe, bus_rd, bus_write, a_rd_valid, b_ack, b_busy});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata, b_rdata} !== 88'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", {bus_addr, bus_wdata, b_rdata});
        end
        n_cmp++;
        if (dfr_count !== '0) begin
            n_err++;
            $display("FAIL reset_dfr: got %0d required 0", dfr_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_a_read();
        logic [89:0] ge, gx;
        logic [63:0] ae, ax;
        a_issue(24'h000010, 1'b1, 32'h0);
        tick(); a_idle();
        tick();
        a_issue(24'h000030, 1'b0, 32'hCAFEF00D);
        tick(); a_idle();
        repeat (LAT + 4) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL a_read_bus: got %h required %h", ge, gx); end
        end
        while (a_exp.size() > 0) begin
            ax = a_exp.pop_front(); ae = '1;
            if (a_obs.size() > 0) ae = a_obs.pop_front();
            n_cmp++;
            if (ae !== ax) begin n_err++; $display("FAIL a_read_data: got cyc/data %h required %h", ae, ax); end
        end
        n_cmp++;
        if (a_obs.size() != 0 || bus_obs.size() != 0) begin
            n_err++;
            $display("FAIL a_read_extra: got %0d a_rd_valid / %0d bus extra, required 0/0", a_obs.size(), bus_obs.size());
        end
        n_cmp++;
        if ({bus_rd, bus_addr, bus_wdata} !== {1'b0, 24'h000030, 32'hCAFEF00D}) begin
            n_err++;
            $display("FAIL bus_hold: got %h required %h", {bus_rd, bus_addr, bus_wdata}, {1'b0, 24'h000030, 32'hCAFEF00D});
        end
    endtask

    task automatic test_b_write();
        logic [89:0] ge, gx;
        logic [63:0] be, bx;
        int t;
        t = cyc;
        b_req = 1'b1; b_addr = 24'h000020; b_rd = 1'b0; b_wdata = 32'h12345678;
        bus_exp.push_back({32'(t + 2), 1'b0, 1'b1, 24'h000020, 32'h12345678});
        b_exp.push_back({32'(t + 2), last_b});
        tick();
        n_cmp++;
        if (b_busy !== 1'b1) begin n_err++; $display("FAIL b_write_busy: got %b required 1", b_busy); end
        b_addr = 24'hFFFFFF; b_wdata = 32'hFFFFFFFF; b_rd = 1'b1;
        tick();
        b_req = 1'b0;
        repeat (4) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL b_write_bus: got %h required %h", ge, gx); end
        end
        while (b_exp.size() > 0) begin
            bx = b_exp.pop_front(); be = '1;
            if (b_obs.size() > 0) be = b_obs.pop_front();
            n_cmp++;
            if (be !== bx) begin n_err++; $display("FAIL b_write_ack: got cyc/data %h required %h", be, bx); end
        end
        n_cmp++;
        if (b_obs.size() != 0 || bus_obs.size() != 0 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b_write_idle: got %0d acks / %0d bus extra / busy %b, required 0/0/0", b_obs.size(), bus_obs.size(), b_busy);
        end
    endtask

    task automatic test_priority();
        logic [89:0] ge, gx;
        logic [63:0] ae, ax, be, bx;
        int t;
        t = cyc;
        b_req = 1'b1; b_addr = 24'h000040; b_rd = 1'b0; b_wdata = 32'hB0B0B0B0;
        tick();
        a_issue(24'h000050, 1'b0, 32'h11111111); dfr_exp++;
        tick();
        a_issue(24'h000060, 1'b1, 32'h0); dfr_exp++;
        tick();
        a_idle();
        bus_exp.push_back({32'(t + 4), 1'b0, 1'b1, 24'h000040, 32'hB0B0B0B0});
        b_exp.push_back({32'(t + 4), last_b});
        tick();
        b_req = 1'b0;
        repeat (LAT + 3) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL priority_bus: got %h required %h", ge, gx); end
        end
        while (a_exp.size() > 0) begin
            ax = a_exp.pop_front(); ae = '1;
            if (a_obs.size() > 0) ae = a_obs.pop_front();
            n_cmp++;
            if (ae !== ax) begin n_err++; $display("FAIL priority_a: got %h required %h", ae, ax); end
        end
        while (b_exp.size() > 0) begin
            bx = b_exp.pop_front(); be = '1;
            if (b_obs.size() > 0) be = b_obs.pop_front();
            n_cmp++;
            if (be !== bx) begin n_err++; $display("FAIL priority_b: got %h required %h", be, bx); end
        end
        n_cmp++;
        if (dfr_count !== DFR_W'(dfr_exp)) begin
            n_err++; $display("FAIL priority_dfr: got %0d required %0d", dfr_count, dfr_exp);
        end
    endtask

    task automatic test_mixed_reads();
        logic [89:0] ge, gx;
        logic [63:0] ae, ax, be, bx;
        int t;
        t = cyc;
        a_issue(24'h000100, 1'b1, 32'h0);
        b_req = 1'b1; b_addr = 24'h000200; b_rd = 1'b1; b_wdata = 32'h0;
        bus_exp.push_back({32'(t + 2), 1'b1, 1'b0, 24'h000200, 32'h0});
        last_b = slave_data(24'h000200);
        b_exp.push_back({32'(t + 3 + LAT), last_b});
        tick(); a_idle();
        for (int i = 0; i < 4 * LAT + 10 && b_req; i++) begin
            tick();
            if (b_ack) b_req = 1'b0;
        end
        b_req = 1'b0;
        repeat (3) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL mixed_bus: got %h required %h", ge, gx); end
        end
        while (a_exp.size() > 0) begin
            ax = a_exp.pop_front(); ae = '1;
            if (a_obs.size() > 0) ae = a_obs.pop_front();
            n_cmp++;
            if (ae !== ax) begin n_err++; $display("FAIL mixed_a: got %h required %h", ae, ax); end
        end
        while (b_exp.size() > 0) begin
            bx = b_exp.pop_front(); be = '1;
            if (b_obs.size() > 0) be = b_obs.pop_front();
            n_cmp++;
            if (be !== bx) begin n_err++; $display("FAIL mixed_b: got %h required %h", be, bx); end
        end
        n_cmp++;
        if (a_obs.size() != 0 || b_obs.size() != 0) begin
            n_err++; $display("FAIL mixed_extra: got %0d a / %0d b extra, required 0/0", a_obs.size(), b_obs.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [89:0] ge, gx;
        logic [63:0] be, bx;
        int t, acks;
        t = cyc;
        b_req = 1'b1; b_addr = 24'h000300; b_rd = 1'b0; b_wdata = 32'h0BADCAFE;
        bus_exp.push_back({32'(t + 2), 1'b0, 1'b1, 24'h000300, 32'h0BADCAFE});
        b_exp.push_back({32'(t + 2), last_b});
        bus_exp.push_back({32'(t + 4), 1'b1, 1'b0, 24'h000310, 32'h0});
        last_b = slave_data(24'h000310);
        b_exp.push_back({32'(t + 5 + LAT), last_b});
        acks = 0;
        for (int i = 0; i < 30 && acks < 2; i++) begin
            tick();
            if (b_ack) begin
                acks++;
                if (acks == 1) begin
                    b_addr = 24'h000310; b_rd = 1'b1; b_wdata = 32'h0;
                end else begin
                    b_req = 1'b0;
                end
            end
        end
        b_req = 1'b0;
        repeat (3) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL b2b_bus: got %h required %h", ge, gx); end
        end
        while (b_exp.size() > 0) begin
            bx = b_exp.pop_front(); be = '1;
            if (b_obs.size() > 0) be = b_obs.pop_front();
            n_cmp++;
            if (be !== bx) begin n_err++; $display("FAIL b2b_ack: got %h required %h", be, bx); end
        end
        n_cmp++;
        if (b_obs.size() != 0 || bus_obs.size() != 0) begin
            n_err++; $display("FAIL b2b_extra: got %0d acks / %0d bus extra, required 0/0", b_obs.size(), bus_obs.size());
        end
    endtask

    task automatic test_reset_mid_read();
        logic [89:0] ge, gx;
        int t;
        t = cyc;
        a_strobe = 1'b1; a_addr = 24'h000400; a_rd = 1'b1; a_wdata = 32'h0;
        bus_exp.push_back({32'(t + 1), 1'b1, 1'b0, 24'h000400, 32'h0});
        b_req = 1'b1; b_addr = 24'h000410; b_rd = 1'b1; b_wdata = 32'h0;
        tick(); a_idle();
        tick();
        b_req = 1'b0;
        n_cmp++;
        if (b_busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before: got %b required 1", b_busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({b_busy, b_ack, bus_strobe} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_busy_after: got busy/ack/strobe %b required 000", {b_busy, b_ack, bus_strobe});
        end
        tick(); tick();
        reset = 1'b0;
        last_b = 32'h0;
        dfr_exp = 0;
        repeat (10) tick();
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL rst_mid_bus: got %h required %h", ge, gx); end
        end
        n_cmp++;
        if (a_obs.size() != 0 || b_obs.size() != 0 || bus_obs.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_ghost: got %0d a_rd_valid / %0d b_ack / %0d bus, required 0/0/0", a_obs.size(), b_obs.size(), bus_obs.size());
        end
        n_cmp++;
        if ({b_rdata, dfr_count} !== {32'h0, DFR_W'(0)}) begin
            n_err++; $display("FAIL rst_mid_state: got b_rdata %h dfr %0d required 0 0", b_rdata, dfr_count);
        end
    endtask

    task automatic test_saturation();
        logic [89:0] ge, gx;
        logic [63:0] be, bx;
        int t;
        t = cyc;
        b_req = 1'b1; b_addr = 24'h000500; b_rd = 1'b0; b_wdata = 32'h55AA55AA;
        tick();
        for (int i = 0; i < 300; i++) begin
            if (i == 1 || i == 254 || i == 255 || i == 299) begin
                n_cmp++;
                if (dfr_count !== DFR_W'(dfr_exp)) begin
                    n_err++; $display("FAIL sat_dfr[%0d]: got %0d required %0d", i, dfr_count, dfr_exp);
                end
            end
            a_issue(24'(24'h000600 + i), 1'b0, 32'(i));
            if (dfr_exp < DFR_MAX) dfr_exp++;
            tick();
        end
        a_idle();
        bus_exp.push_back({32'(t + 302), 1'b0, 1'b1, 24'h000500, 32'h55AA55AA});
        b_exp.push_back({32'(t + 302), last_b});
        tick();
        b_req = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (dfr_count !== DFR_W'(dfr_exp)) begin
            n_err++; $display("FAIL sat_hold: got %0d required %0d", dfr_count, dfr_exp);
        end
        while (bus_exp.size() > 0) begin
            gx = bus_exp.pop_front(); ge = '1;
            if (bus_obs.size() > 0) ge = bus_obs.pop_front();
            n_cmp++;
            if (ge !== gx) begin n_err++; $display("FAIL sat_bus: got %h required %h", ge, gx); end
        end
        while (b_exp.size() > 0) begin
            bx = b_exp.pop_front(); be = '1;
            if (b_obs.size() > 0) be = b_obs.pop_front();
            n_cmp++;
            if (be !== bx) begin n_err++; $display("FAIL sat_ack: got %h required %h", be, bx); end
        end
    endtask

    initial begin
        a_addr = '0; a_strobe = 1'b0; a_rd = 1'b0; a_wdata = '0;
        b_req = 1'b0; b_addr = '0; b_rd = 1'b0; b_wdata = '0;
        test_reset();
        test_a_read();
        test_b_write();
        test_priority();
        test_mixed_reads();
        test_back_to_back();
        test_reset_mid_read();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
